// File: rtl/idev_input_fifo.sv
// idev_input_fifo: byte FIFO feeding the CPU in_idev0 input port.
// Latency: a pushed byte is readable the cycle after its push edge; a data read
// returns the head byte combinationally (first-word fall-through). Backpressure:
// src_ready = !full, taken from the registered count only.
//
// Ports:
//   clk            system clock, rising edge
//   rst_pb_bar     asynchronous active-low reset
//   src_data/src_valid/src_ready  producer handshake (transfer on valid & ready)
//   io_rd/io_addr  CPU input-read strobe and io address
//   underflow_clr  clears the sticky underflow flag
//   idev_data      byte presented to the CPU
//   empty/full/count/underflow    occupancy and error status
//
// Optional feature: define IDEV_STATUS_EN to map a status byte
// {underflow, full, empty, count[4:0]} at STAT_ADDR. Without it STAT_ADDR reads
// as an unmapped address (8'h00).

module idev_input_fifo #(
  parameter int          DEPTH     = 16,
  parameter logic [11:0] DATA_ADDR = 12'h000,
  parameter logic [11:0] STAT_ADDR = 12'h001
) (
  input  logic        clk,
  input  logic        rst_pb_bar,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        io_rd,
  input  logic [11:0] io_addr,
  input  logic        underflow_clr,
  output logic [7:0]  idev_data,
  output logic        empty,
  output logic        full,
  output logic [4:0]  count,
  output logic        underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic data_rd;
  logic stat_rd;
  logic push;
  logic pop;

  assign empty     = (count == 5'd0);
  assign full      = (count == 5'(DEPTH));
  assign src_ready = !full;

  assign data_rd = io_rd && (io_addr == DATA_ADDR);
  assign stat_rd = io_rd && (io_addr == STAT_ADDR);
  assign push    = src_valid && src_ready;
  assign pop     = data_rd && !empty;

  // Storage is deliberately not reset; contents are only visible through the
  // pointers, which are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_pb_bar) begin
    if (!rst_pb_bar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear so an underflow in the same cycle as a clear is kept.
  always_ff @(posedge clk or negedge rst_pb_bar) begin
    if (!rst_pb_bar) begin
      underflow <= 1'b0;
    end else if (data_rd && empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  // A push into an empty FIFO is not bypassed: the head byte is only shown
  // once count is nonzero.
  always_comb begin
    idev_data = 8'h00;
    if (data_rd) begin
      if (!empty) begin
        idev_data = mem[rd_ptr];
      end
    end
`ifdef IDEV_STATUS_EN
    else if (stat_rd) begin
      idev_data = {underflow, full, empty, count};
    end
`else
    else if (stat_rd) begin
      idev_data = 8'h00;
    end
`endif
  end

endmodule

// File: tb/tb_idev_input_fifo.sv
module tb_idev_input_fifo;

  localparam logic [11:0] DA = 12'h000;
  localparam logic [11:0] SA = 12'h001;
  localparam logic [11:0] OA = 12'h005;

`ifdef IDEV_STATUS_EN
  localparam logic [7:0] ST_CNT2  = 8'h02;
  localparam logic [7:0] ST_EMPUF = 8'hA0;
`else
  localparam logic [7:0] ST_CNT2  = 8'h00;
  localparam logic [7:0] ST_EMPUF = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_pb_bar;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        io_rd;
  logic [11:0] io_addr;
  logic        underflow_clr;
  logic [7:0]  idev_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  idev_input_fifo #(.DEPTH(16), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
    .clk           (clk),
    .rst_pb_bar    (rst_pb_bar),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .io_rd         (io_rd),
    .io_addr       (io_addr),
    .underflow_clr (underflow_clr),
    .idev_data     (idev_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rd;
    logic [11:0] a;
    logic        clr;
    logic [7:0]  e_data;
    logic [4:0]  e_cnt;
    logic        e_uf;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rd,
                       input logic [11:0] a, input logic clr);
    src_valid     = v;
    src_data      = d;
    io_rd         = rd;
    io_addr       = a;
    underflow_clr = clr;
  endtask

  // Outputs are checked mid-cycle, after inputs settle and before the next edge.
  task automatic check_state(input string nm, input logic [7:0] e_data,
                             input logic [4:0] e_cnt, input logic e_uf);
    chk({nm, " data"},  32'(idev_data), 32'(e_data));
    chk({nm, " count"}, 32'(count),     32'(e_cnt));
    chk({nm, " empty"}, 32'(empty),     32'(e_cnt == 5'd0));
    chk({nm, " full"},  32'(full),      32'(e_cnt == 5'd16));
    chk({nm, " ready"}, 32'(src_ready), 32'(e_cnt != 5'd16));
    chk({nm, " uf"},    32'(underflow), 32'(e_uf));
  endtask

  initial begin
    // v, d, rd, a, clr | data, count, uf  (expected values seen before the edge)
    vecs[0]  = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, DA, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'hA5, 5'd2, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h3C, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, DA, 1'b1, 8'h00, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, DA, 1'b1, 8'h00, 5'd0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b1};
    vecs[13] = '{1'b1, 8'h5A, 1'b1, DA, 1'b0, 8'h00, 5'd0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h5A, 5'd1, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, DA, 1'b1, 8'h00, 5'd0, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[17] = '{1'b1, 8'h01, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[18] = '{1'b1, 8'h02, 1'b0, DA, 1'b0, 8'h00, 5'd1, 1'b0};
    vecs[19] = '{1'b1, 8'h03, 1'b0, DA, 1'b0, 8'h00, 5'd2, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b1, OA, 1'b0, 8'h00, 5'd3, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd3, 1'b0};
    vecs[22] = '{1'b1, 8'h11, 1'b1, DA, 1'b0, 8'h01, 5'd3, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h02, 5'd3, 1'b0};
    vecs[24] = '{1'b0, 8'h00, 1'b1, SA, 1'b0, ST_CNT2, 5'd2, 1'b0};
    vecs[25] = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h03, 5'd2, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h11, 5'd1, 1'b0};
    vecs[27] = '{1'b0, 8'h00, 1'b1, DA, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[28] = '{1'b0, 8'h00, 1'b1, SA, 1'b0, ST_EMPUF, 5'd0, 1'b1};
    vecs[29] = '{1'b0, 8'h00, 1'b0, DA, 1'b1, 8'h00, 5'd0, 1'b1};
    vecs[30] = '{1'b0, 8'h00, 1'b0, DA, 1'b0, 8'h00, 5'd0, 1'b0};

    // Reset held for two cycles with a pending push and read on the inputs.
    rst_pb_bar = 1'b0;
    drive(1'b1, 8'hEE, 1'b1, DA, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset count", 32'(count),     32'd0);
    chk("reset empty", 32'(empty),     32'd1);
    chk("reset full",  32'(full),      32'd0);
    chk("reset ready", 32'(src_ready), 32'd1);
    chk("reset uf",    32'(underflow), 32'd0);
    drive(1'b0, 8'h00, 1'b0, DA, 1'b0);
    #1;
    chk("reset data",  32'(idev_data), 32'd0);
    rst_pb_bar = 1'b1;

    // Table-driven section.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].a, vecs[i].clr);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_uf);
    end

    // Fill to full with 00..0F.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(i), 1'b0, DA, 1'b0);
    end
    // Offer FF while full for two cycles; it must be refused.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 8'hFF, 1'b0, DA, 1'b0);
      #1;
      check_state($sformatf("full_hold%0d", i), 8'h00, 5'd16, 1'b0);
    end
    // Drain; the first read happens while full and frees one slot.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b1, DA, 1'b0);
      #1;
      check_state($sformatf("drain%0d", i), 8'(i), 5'(16 - i), 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, DA, 1'b0);
    #1;
    check_state("drained", 8'h00, 5'd0, 1'b0);

    // Pointers have wrapped; one more byte through.
    @(negedge clk);
    drive(1'b1, 8'h77, 1'b0, DA, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, DA, 1'b0);
    #1;
    check_state("wrap77", 8'h77, 5'd1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, DA, 1'b0);
    #1;
    check_state("wrap_empty", 8'h00, 5'd0, 1'b0);

    // Reset mid-operation discards contents.
    @(negedge clk);
    drive(1'b1, 8'h42, 1'b0, DA, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h43, 1'b0, DA, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, DA, 1'b0);
    #1;
    check_state("pre_rst", 8'h42, 5'd2, 1'b0);
    rst_pb_bar = 1'b0;
    #1;
    check_state("mid_rst", 8'h00, 5'd0, 1'b0);
    @(negedge clk);
    rst_pb_bar = 1'b1;
    drive(1'b0, 8'h00, 1'b0, DA, 1'b0);
    #1;
    check_state("post_rst", 8'h00, 5'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
